i2c_byte_engine: RTL and testbench
==================================

# i2c_byte_engine

Parametrised bit-level transfer engine for the I2C master: shifts one DATA_W-bit word plus one acknowledge slot on SCL/SDA, in either direction, using the four-quarter-phase bit sequence (data1..data4) with a programmable phase divisor. It sits between the master's command sequencer, which issues START/STOP and word commands, and the open-drain pad drivers. It generalises the fixed 8-bit write-only data phase with configurable word width, read mode with master ACK/NACK, sampled receive data, and optional clock stretching.

## Interface
- DATA_W, 8, data bits per transfer (≥1); slot count = DATA_W+1
- DIV_W, 16, width of phase divisor and phase counter
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- clock_divisor  in  DIV_W  phase length minus one, in clk cycles
- start  in  1  transfer request; accepted only in IDLE
- rw  in  1  0 = write tx_data, 1 = read
- nack  in  1  read only: value driven in ack slot (0 = ACK)
- tx_data  in  DATA_W  write word, MSB first
- sda_i  in  1  sampled SDA line
- scl_i  in  1  sampled SCL line (used only with stretching)
- scl_o  out  1  1 = release SCL, 0 = pull low
- sda_o  out  1  1 = release SDA, 0 = pull low
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle pulse at transfer end
- rx_data  out  DATA_W  word sampled from SDA (valid from done)
- ack_in  out  1  SDA sampled in ack slot (0 = ACK received)

## Operation
- States: IDLE, DATA1, DATA2, DATA3, DATA4, DATA_END; encodings in shared constants.
- Start in IDLE: latch clock_divisor into div_reg; load tx_reg (DATA_W+1 bits) = {tx_data,1} for write, {all ones, nack} for read; bit_reg=0, ctr_reg=0; → DATA1. Start outside IDLE ignored.
- Each data state lasts div_reg+1 cycles: ctr_reg increments; when ctr_reg == div_reg, ctr_reg ← 0 and state advances.
- DATA1: scl_o=0, sda_o=tx_reg[MSB]. DATA2, DATA3: scl_o=1, sda_o held. DATA4: scl_o=0, sda_o held.
- Exit of DATA3: shift sda_i into rx shift register (DATA_W+1 bits, LSB in).
- Exit of DATA4: if bit_reg == DATA_W → DATA_END, bit_reg ← 0, tx_reg unchanged; else tx_reg ← tx_reg<<1 (zero fill), bit_reg+1, → DATA1.
- DATA_END (one cycle): done=1; rx_data ← rx shift[DATA_W:1]; ack_in ← rx shift[0]; → IDLE.
- IDLE: scl_o/sda_o hold last value (SCL stays low after a transfer); rx_data, ack_in hold until next done.
- bit_reg width = clog2(DATA_W+1); ctr_reg DIV_W bits, never wraps past div_reg.

## Timing
- Reset values: state IDLE, scl_o=1, sda_o=1, busy=0, done=0, rx_data=0, ack_in=1, ctr_reg=0, bit_reg=0.
- Reset mid-transfer: immediate return to reset values; no done pulse.
- busy rises the cycle after start is sampled; done asserts (DATA_W+1)·4·(div_reg+1) cycles after busy rises; busy falls with done's falling edge.
- clock_divisor=0: one-cycle phases, 4-cycle bits. Changes to clock_divisor mid-transfer have no effect.
- start asserted on the same cycle as done: ignored (engine not yet IDLE).

## Configuration
- I2C_CLOCK_STRETCH_EN defined: in DATA2, while scl_i==0, ctr_reg holds and the state does not advance; the phase count begins once scl_i reads 1.
- Undefined: scl_i ignored; DATA2 always lasts div_reg+1 cycles.

## Structure
- Shared i2c.vh: state constants (k_idle, k_data1..k_data4, k_data_end), ACK/NACK constants.
- One sub-module: i2c_phase_counter (div_reg compare, ctr_reg, hold input for stretching, tick output).

## Test plan
- Write DATA_W=8, divisor 3, tx_data=0xA5, sda_i=sda_o except ack slot driven 0 → SDA bit sequence 1,0,1,0,0,1,0,1,release; done at cycle 144; rx_data=0xA5, ack_in=0.
- Read, nack=1, slave drives 0x3C → sda_o released for 8 bits, 1 in ack slot; rx_data=0x3C, ack_in=1.
- Divisor 0, DATA_W=12 → done 52 cycles after busy rises; each SCL phase one cycle.
- Start asserted while busy and on the done cycle → ignored; second transfer only after IDLE.
- Reset asserted during DATA3 of bit 4 → scl_o=1, sda_o=1, busy=0 immediately, no done.
- With I2C_CLOCK_STRETCH_EN, scl_i held low 10 cycles in DATA2 of bit 0 → done delayed exactly 10 cycles; without macro, no delay.

Source files
------------

// File: rtl/i2c_byte_engine_pkg.sv
// Shared state encodings and acknowledge levels for the I2C byte engine.
package i2c_byte_engine_pkg;

    localparam logic [2:0] k_idle     = 3'd0;
    localparam logic [2:0] k_data1    = 3'd1;
    localparam logic [2:0] k_data2    = 3'd2;
    localparam logic [2:0] k_data3    = 3'd3;
    localparam logic [2:0] k_data4    = 3'd4;
    localparam logic [2:0] k_data_end = 3'd5;

    localparam logic k_ack  = 1'b0;
    localparam logic k_nack = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE     = k_idle,
        ST_DATA1    = k_data1,
        ST_DATA2    = k_data2,
        ST_DATA3    = k_data3,
        ST_DATA4    = k_data4,
        ST_DATA_END = k_data_end
    } state_t;

    function automatic logic is_data_phase(state_t s);
        return (s == ST_DATA1) || (s == ST_DATA2) || (s == ST_DATA3) || (s == ST_DATA4);
    endfunction

endpackage

// File: rtl/i2c_byte_engine_if.sv
// Command/status and pad-side signals of the I2C byte engine.
interface i2c_byte_engine_if #(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 16
);
    logic [DIV_W-1:0]  clock_divisor;
    logic              start;
    logic              rw;
    logic              nack;
    logic [DATA_W-1:0] tx_data;
    logic              sda_i;
    logic              scl_i;
    logic              scl_o;
    logic              sda_o;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] rx_data;
    logic              ack_in;

    modport master (
        output clock_divisor, start, rw, nack, tx_data, sda_i, scl_i,
        input  scl_o, sda_o, busy, done, rx_data, ack_in
    );

    modport slave (
        input  clock_divisor, start, rw, nack, tx_data, sda_i, scl_i,
        output scl_o, sda_o, busy, done, rx_data, ack_in
    );
endinterface

// File: rtl/i2c_byte_engine_phase_counter.sv
// Quarter-phase timer: counts 0..div while running, pulses tick on the last cycle.
module i2c_byte_engine_phase_counter #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             hold,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);
    logic [DIV_W-1:0] ctr_reg;

    assign tick = run && !hold && (ctr_reg == div);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctr_reg <= '0;
        end else if (run && !hold) begin
            ctr_reg <= (ctr_reg == div) ? '0 : ctr_reg + 1'b1;
        end
    end
endmodule

// File: rtl/i2c_byte_engine.sv
// I2C bit-level engine: one DATA_W-bit word plus ACK slot per transfer, read or write.
// Optional SCL stretching in DATA2 when I2C_CLOCK_STRETCH_EN is defined.
module i2c_byte_engine
    import i2c_byte_engine_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 16
) (
    input logic              clk,
    input logic              reset,
    i2c_byte_engine_if.slave bus
);
    localparam int               BIT_W    = $clog2(DATA_W + 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W);

    state_t            state;
    logic [DIV_W-1:0]  div_reg;
    logic [DATA_W:0]   tx_reg;
    logic [DATA_W:0]   rx_shift;
    logic [DATA_W:0]   load_word;
    logic [BIT_W-1:0]  bit_reg;
    logic              scl_reg;
    logic              sda_reg;
    logic [DATA_W-1:0] rx_reg;
    logic              ack_reg;
    logic              accept;
    logic              tick;
    logic              hold;
    logic              last_bit;

    assign accept    = bus.start && (state == ST_IDLE);
    assign last_bit  = (bit_reg == LAST_BIT);
    // Writes release SDA in the ACK slot; reads release SDA for the data bits.
    assign load_word = bus.rw ? {{DATA_W{1'b1}}, bus.nack} : {bus.tx_data, k_nack};

`ifdef I2C_CLOCK_STRETCH_EN
    assign hold = (state == ST_DATA2) && !bus.scl_i;
`else
    logic unused_scl;
    assign unused_scl = bus.scl_i;
    assign hold       = 1'b0;
`endif

    i2c_byte_engine_phase_counter #(.DIV_W(DIV_W)) u_phase (
        .clk   (clk),
        .reset (reset),
        .run   (is_data_phase(state)),
        .hold  (hold),
        .div   (div_reg),
        .tick  (tick)
    );

    // Word shift registers carry no reset; they are reloaded on every accepted start.
    always_ff @(posedge clk) begin
        if (accept) begin
            div_reg <= bus.clock_divisor;
            tx_reg  <= load_word;
        end else if (tick && (state == ST_DATA4) && !last_bit) begin
            tx_reg <= {tx_reg[DATA_W-1:0], 1'b0};
        end
        if (tick && (state == ST_DATA3)) begin
            rx_shift <= {rx_shift[DATA_W-1:0], bus.sda_i};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            scl_reg <= 1'b1;
            sda_reg <= 1'b1;
            rx_reg  <= '0;
            ack_reg <= k_nack;
            bit_reg <= '0;
        end else begin
            case (state)
                ST_IDLE: if (bus.start) begin
                    state   <= ST_DATA1;
                    scl_reg <= 1'b0;
                    sda_reg <= load_word[DATA_W];
                    bit_reg <= '0;
                end
                ST_DATA1: if (tick) begin
                    state   <= ST_DATA2;
                    scl_reg <= 1'b1;
                end
                ST_DATA2: if (tick) state <= ST_DATA3;
                ST_DATA3: if (tick) begin
                    state   <= ST_DATA4;
                    scl_reg <= 1'b0;
                end
                ST_DATA4: if (tick) begin
                    if (last_bit) begin
                        state   <= ST_DATA_END;
                        bit_reg <= '0;
                        rx_reg  <= rx_shift[DATA_W:1];
                        ack_reg <= rx_shift[0];
                    end else begin
                        state   <= ST_DATA1;
                        bit_reg <= bit_reg + 1'b1;
                        sda_reg <= tx_reg[DATA_W-1];
                    end
                end
                ST_DATA_END: state <= ST_IDLE;
                default:     state <= ST_IDLE;
            endcase
        end
    end

    assign bus.scl_o   = scl_reg;
    assign bus.sda_o   = sda_reg;
    assign bus.busy    = (state != ST_IDLE);
    assign bus.done    = (state == ST_DATA_END);
    assign bus.rx_data = rx_reg;
    assign bus.ack_in  = ack_reg;
endmodule

// File: tb/tb_i2c_byte_engine.sv
// Scoreboard bench for i2c_byte_engine: random transfers against a word-level bus model.
module tb_i2c_byte_engine;
    localparam int DW = 8;
    localparam int VW = 16;

    typedef struct {
        logic [DW-1:0] rx;
        logic          ack;
        int            lat;
        logic [DW:0]   sda;
    } exp_t;

    logic clk;
    logic reset;
    logic stretch_pull;
    logic [DW:0] slave_bits;
    logic [DW:0] slave_sh;
    exp_t exp_q[$];
    int checks   = 0;
    int failures = 0;

    i2c_byte_engine_if #(.DATA_W(DW), .DIV_W(VW)) bus ();

    i2c_byte_engine #(.DATA_W(DW), .DIV_W(VW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Open-drain wired-AND lines: master pad, bench slave and bench clock stretcher.
    assign bus.sda_i = bus.sda_o & slave_sh[DW];
    assign bus.scl_i = bus.scl_o & ~stretch_pull;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endfunction

    // Monitor: tracks the bus, drives the slave bits and scores every done pulse.
    initial begin
        logic        scl_q;
        logic        busy_q;
        logic        done_q;
        int          cyc;
        int          rise;
        int          nseen;
        logic [DW:0] seen;
        exp_t        e;
        scl_q = 1'b1; busy_q = 1'b0; done_q = 1'b0;
        cyc = 0; rise = 0; nseen = 0; seen = '0;
        slave_sh = '1;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                slave_sh = '1; scl_q = 1'b1; busy_q = 1'b0; done_q = 1'b0;
            end else begin
                if (done_q) chk("busy_after_done", 64'(bus.busy), 64'(0));
                if (bus.busy && !busy_q) begin
                    rise = cyc; nseen = 0; seen = '0; slave_sh = slave_bits;
                end
                if (bus.busy && bus.scl_o && !scl_q) begin
                    seen = {seen[DW-1:0], bus.sda_o};
                    nseen++;
                end
                if (bus.busy && busy_q && scl_q && !bus.scl_o) slave_sh = {slave_sh[DW-1:0], 1'b1};
                if (!bus.busy) slave_sh = '1;
                if (bus.done) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_done", 64'(1), 64'(0));
                    end else begin
                        e = exp_q.pop_front();
                        chk("rx_data", 64'(bus.rx_data), 64'(e.rx));
                        chk("ack_in", 64'(bus.ack_in), 64'(e.ack));
                        chk("latency", 64'(cyc - rise), 64'(e.lat));
                        chk("sda_seq", 64'(seen), 64'(e.sda));
                        chk("slot_count", 64'(nseen), 64'(DW + 1));
                    end
                end
                scl_q = bus.scl_o; busy_q = bus.busy; done_q = bus.done;
            end
        end
    end

    task automatic launch(input logic r, input logic n, input logic [DW-1:0] tx,
                          input logic [DW-1:0] sw, input logic sack, input int div,
                          input bit push, input bit stretch);
        exp_t e;
        bus.rw = r; bus.nack = n; bus.tx_data = tx;
        bus.clock_divisor = div[VW-1:0];
        slave_bits = r ? {sw, 1'b1} : {{DW{1'b1}}, sack};
        if (push) begin
            e.rx  = r ? sw : tx;
            e.ack = r ? n : sack;
            e.lat = (DW + 1) * 4 * (div + 1);
`ifdef I2C_CLOCK_STRETCH_EN
            if (stretch) e.lat += 10;
`endif
            e.sda = r ? {{DW{1'b1}}, n} : {tx, 1'b1};
            exp_q.push_back(e);
        end
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.clock_divisor = VW'($urandom);
        if (stretch) begin
            repeat (div + 1) @(posedge clk);
            #1 stretch_pull = 1'b1;
            repeat (10) @(posedge clk);
            #1 stretch_pull = 1'b0;
        end
    endtask

    task automatic wait_idle(string nm);
        int i;
        i = 0;
        while (bus.busy && i < 5000) begin
            @(posedge clk); #1;
            i++;
        end
        chk(nm, 64'(bus.busy), 64'(0));
    endtask

    initial begin
        int   r5;
        int   n;
        logic prev;
        reset = 1'b1;
        stretch_pull = 1'b0;
        slave_bits = '1;
        bus.start = 1'b0; bus.rw = 1'b0; bus.nack = 1'b0;
        bus.tx_data = '0; bus.clock_divisor = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_scl", 64'(bus.scl_o), 64'(1));
        chk("rst_sda", 64'(bus.sda_o), 64'(1));
        chk("rst_busy", 64'(bus.busy), 64'(0));
        chk("rst_done", 64'(bus.done), 64'(0));
        chk("rst_rx", 64'(bus.rx_data), 64'(0));
        chk("rst_ack", 64'(bus.ack_in), 64'(1));
        reset = 1'b0;
        @(posedge clk); #1;

        launch(1'b0, 1'b0, 8'hA5, 8'h00, 1'b0, 3, 1'b1, 1'b0);
        wait_idle("idle_write_a5");
        launch(1'b1, 1'b1, 8'h00, 8'h3C, 1'b1, 3, 1'b1, 1'b0);
        wait_idle("idle_read_3c");
        launch(1'b0, 1'b0, 8'h5E, 8'h00, 1'b1, 0, 1'b1, 1'b0);
        wait_idle("idle_div0");

        // Starts while busy and on the done cycle must be ignored.
        launch(1'b1, 1'b0, 8'h00, 8'hC3, 1'b1, 1, 1'b1, 1'b0);
        repeat (20) @(posedge clk);
        #1 bus.start = 1'b1; bus.rw = 1'b0; bus.tx_data = 8'h11;
        @(posedge clk); #1 bus.start = 1'b0;
        n = 0;
        while (!bus.done && n < 5000) begin
            @(negedge clk);
            n++;
        end
        bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("start_on_done_ignored", 64'(bus.busy), 64'(0));

        // Reset during DATA3 of bit 4: no done, immediate reset values.
        launch(1'b0, 1'b0, 8'hF0, 8'h00, 1'b0, 3, 1'b0, 1'b0);
        r5 = 0; n = 0; prev = bus.scl_o;
        while (r5 < 5 && n < 5000) begin
            @(posedge clk); #1;
            if (bus.scl_o && !prev) r5++;
            prev = bus.scl_o;
            n++;
        end
        repeat (4) @(posedge clk);
        #2 chk("pre_reset_scl_high", 64'(bus.scl_o), 64'(1));
        reset = 1'b1;
        #1;
        chk("abort_scl", 64'(bus.scl_o), 64'(1));
        chk("abort_sda", 64'(bus.sda_o), 64'(1));
        chk("abort_busy", 64'(bus.busy), 64'(0));
        chk("abort_done", 64'(bus.done), 64'(0));
        chk("abort_rx", 64'(bus.rx_data), 64'(0));
        chk("abort_ack", 64'(bus.ack_in), 64'(1));
        @(posedge clk); #1 reset = 1'b0;
        repeat (200) @(posedge clk);
        #1 chk("abort_stays_idle", 64'(bus.busy), 64'(0));

        launch(1'b0, 1'b0, 8'h96, 8'h00, 1'b0, 2, 1'b1, 1'b1);
        wait_idle("idle_stretch");

        for (int k = 0; k < 20; k++) begin
            launch(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), DW'($urandom),
                   DW'($urandom), 1'($urandom_range(1, 0)), int'($urandom_range(3, 0)),
                   1'b1, ($urandom_range(3, 0) == 0));
            wait_idle("idle_random");
        end

        repeat (5) @(posedge clk);
        #1 chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
